// File: rtl/scan_bist_pkg.sv
// Shared constants and types for the scan BIST controller and its LFSR/MISR shifter.
package scan_bist_pkg;

  localparam int          LFSR_W       = 16;
  localparam int          FIFO_DW      = 10;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
    return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
  endfunction

endpackage

// File: rtl/scan_lfsr16.sv
// 16-bit feedback shifter used both as pattern LFSR and as signature MISR.
module scan_lfsr16
  import scan_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              ser_in,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = {q_q[LFSR_W-2:0], lfsr_fb(q_q) ^ ser_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/scan_bist_ctrl.sv
// Scan BIST sequencer: LFSR patterns into the FIFO scan chain, MISR compaction of scan-out.
//   state   | meaning
//   IDLE    | waiting for start, FIFO in functional mode
//   SHIFT   | loading CHAIN_LEN LFSR bits (and unloading the previous response)
//   CAPTURE | one functional clock driven from the LFSR
//   UNLOAD  | flushing the last response into the MISR
//   DONE    | signature compared, pass/done held until next start
module scan_bist_ctrl
  import scan_bist_pkg::*;
#(
  parameter int          CHAIN_LEN    = 32,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [15:0] SEED         = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LFSR_W-1:0]  golden,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [LFSR_W-1:0]  signature,
  output logic               TM,
  output logic               SI,
  input  logic               SO,
  output logic               fifo_read,
  output logic               fifo_write,
  output logic [FIFO_DW-1:0] fifo_d_in
);

  localparam int SCW = $clog2(CHAIN_LEN) + 1;
  localparam int PCW = $clog2(NUM_PATTERNS) + 1;

  state_e         state_q, state_d;
  logic [SCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
  logic           first_pass_q, first_pass_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;

  logic              lfsr_en, lfsr_ld, misr_en, misr_ld;
  logic [LFSR_W-1:0] lfsr, misr, misr_step;
  logic              lfsr_unused;

  // First SHIFT pass flushes unknown power-on chain contents, so it is kept out of the MISR.
  assign misr_step   = {misr[LFSR_W-2:0], lfsr_fb(misr) ^ SO};
  assign lfsr_unused = ^lfsr[14:12];

  always_comb begin
    state_d      = state_q;
    shift_cnt_d  = shift_cnt_q;
    pat_cnt_d    = pat_cnt_q;
    first_pass_d = first_pass_q;
    done_d       = done_q;
    pass_d       = pass_q;
    lfsr_en      = 1'b0;
    lfsr_ld      = 1'b0;
    misr_en      = 1'b0;
    misr_ld      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SHIFT;
          lfsr_ld      = 1'b1;
          misr_ld      = 1'b1;
          shift_cnt_d  = '0;
          pat_cnt_d    = '0;
          first_pass_d = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_SHIFT: begin
        lfsr_en = 1'b1;
        misr_en = ~first_pass_q;
        if (shift_cnt_q == SCW'(CHAIN_LEN - 1)) begin
          shift_cnt_d = '0;
          state_d     = ST_CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        pat_cnt_d    = pat_cnt_q + 1'b1;
        first_pass_d = 1'b0;
        state_d      = (pat_cnt_q == PCW'(NUM_PATTERNS - 1)) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        misr_en = 1'b1;
        if (shift_cnt_q == SCW'(CHAIN_LEN - 1)) begin
          shift_cnt_d = '0;
          state_d     = ST_DONE;
          done_d      = 1'b1;
          pass_d      = (misr_step == golden);
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_cnt_q  <= '0;
      pat_cnt_q    <= '0;
      first_pass_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_cnt_q  <= shift_cnt_d;
      pat_cnt_q    <= pat_cnt_d;
      first_pass_q <= first_pass_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  scan_lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (lfsr_en),
    .load     (lfsr_ld),
    .load_val (SEED),
    .ser_in   (1'b0),
    .q        (lfsr)
  );

  scan_lfsr16 u_misr (
    .clk      (clk),
    .rst      (rst),
    .en       (misr_en),
    .load     (misr_ld),
    .load_val ('0),
    .ser_in   (SO),
    .q        (misr)
  );

  assign busy       = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE) || (state_q == ST_UNLOAD);
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = misr;
  assign TM         = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign SI         = (state_q == ST_SHIFT) & lfsr[15];
  assign fifo_d_in  = (state_q == ST_CAPTURE) ? lfsr[FIFO_DW-1:0] : '0;
  assign fifo_write = (state_q == ST_CAPTURE) & lfsr[10];
  assign fifo_read  = (state_q == ST_CAPTURE) & lfsr[11];

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed + randomized bench for scan_bist_ctrl with a 4-flop scan chain stand-in for the FIFO.
module tb_scan_bist_ctrl;

  localparam int          CL   = 4;
  localparam int          NP   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] golden;
  logic        busy, done, pass, TM, SI, SO, fifo_read, fifo_write;
  logic [15:0] signature;
  logic [9:0]  fifo_d_in;

  logic [CL-1:0] chain, chain_init;
  logic          chain_ld = 1'b0;
  logic          so_zero = 1'b0;
  logic          so_flip = 1'b0;

  int tests = 0;
  int fails = 0;

  logic      tm_log [1:20];
  logic      si_log [1:20];
  logic [9:0] fd_cap;
  logic       fw_cap;

  always #5 clk = ~clk;

  scan_bist_ctrl #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .golden     (golden),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .TM         (TM),
    .SI         (SI),
    .SO         (SO),
    .fifo_read  (fifo_read),
    .fifo_write (fifo_write),
    .fifo_d_in  (fifo_d_in)
  );

  // FIFO scan chain stand-in: shifts under TM, captures an XOR of the functional inputs otherwise.
  assign SO = so_zero ? 1'b0 : (chain[CL-1] ^ so_flip);

  always @(posedge clk) begin
    if (chain_ld)
      chain <= chain_init;
    else if (TM)
      chain <= {chain[CL-2:0], SI};
    else if (busy)
      chain <= chain ^ fifo_d_in[CL-1:0] ^ {CL{fifo_write}};
  end

  function automatic logic [15:0] step16(input logic [15:0] v, input logic b);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ b};
  endfunction

  function automatic logic [15:0] seed_after(input int n);
    logic [15:0] v = SEED;
    for (int i = 0; i < n; i++) v = step16(v, 1'b0);
    return v;
  endfunction

  // Whole-run reference: pattern stream, chain response and compaction in plain loops.
  function automatic logic [15:0] ref_sig(input logic [CL-1:0] init);
    logic [15:0]   lf = SEED;
    logic [15:0]   ms = '0;
    logic [CL-1:0] ch = init;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < CL; k++) begin
        if (p > 0) ms = step16(ms, ch[CL-1]);
        ch = {ch[CL-2:0], lf[15]};
        lf = step16(lf, 1'b0);
      end
      ch = ch ^ lf[CL-1:0] ^ {CL{lf[10]}};
    end
    for (int k = 0; k < CL; k++) begin
      ms = step16(ms, ch[CL-1]);
      ch = {ch[CL-2:0], 1'b0};
    end
    return ms;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_chain(input logic [CL-1:0] v);
    chain_init = v;
    chain_ld   = 1'b1;
    tick;
    chain_ld   = 1'b0;
  endtask

  task automatic do_run(input bit mid_start, input int flip_at, output int len);
    len   = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int s = 1; s <= 60; s++) begin
      if (done) begin
        len = s - 1;
        break;
      end
      tm_log[(s > 20) ? 20 : s] = TM;
      si_log[(s > 20) ? 20 : s] = SI;
      if (s == CL + 1) begin
        fd_cap = fifo_d_in;
        fw_cap = fifo_write;
      end
      start   = (mid_start && s == 3);
      so_flip = (flip_at == s);
      tick;
    end
    start   = 1'b0;
    so_flip = 1'b0;
    check("run_len", len, NP * (CL + 1) + CL);
  endtask

  initial begin
    int          len;
    logic [15:0] sig_a, exp_sig, exp_lf;
    logic [CL-1:0] init;

    rst    = 1'b1;
    start  = 1'b1;
    golden = '0;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_tm", TM, 0);
    check("rst_si", SI, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_fifo_write", fifo_write, 0);
    check("rst_fifo_d_in", fifo_d_in, 0);
    check("rst_signature", signature, 0);
    rst = 1'b0;
    check("idle_until_rst_release", busy, 0);
    tick;
    check("start_after_rst_release", busy, 1);
    rst   = 1'b1;
    start = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    // Run A: directed timing checks plus bit-exact signature
    init = CL'($urandom);
    load_chain(init);
    exp_sig = ref_sig(init);
    golden  = exp_sig;
    do_run(1'b0, -1, len);
    check("si_c1", si_log[1], 1);
    check("si_c2", si_log[2], 0);
    check("si_c3", si_log[3], 1);
    check("si_c4", si_log[4], 0);
    check("tm_c1_4", {tm_log[1], tm_log[2], tm_log[3], tm_log[4]}, 4'b1111);
    check("tm_capture1", tm_log[CL + 1], 0);
    check("tm_capture2", tm_log[2 * (CL + 1)], 0);
    check("tm_unload", tm_log[2 * (CL + 1) + 1], 1);
    exp_lf = seed_after(CL);
    check("capture_d_in", fd_cap, exp_lf[9:0]);
    check("capture_write", fw_cap, exp_lf[10]);
    check("sig_a", signature, exp_sig);
    check("pass_a", pass, 1);
    check("done_a", done, 1);
    sig_a = signature;
    repeat (3) tick;
    check("done_held", done, 1);
    check("busy_done", busy, 0);

    // Restart from DONE with a start pulse in mid-SHIFT that must be ignored
    load_chain(CL'($urandom));
    do_run(1'b1, -1, len);
    check("restart_sig", signature, sig_a);
    check("restart_pass", pass, 1);

    // Random chain contents and goldens
    for (int r = 0; r < 4; r++) begin
      init = CL'($urandom);
      load_chain(init);
      exp_sig = ref_sig(init);
      golden  = ($urandom_range(0, 1) == 1) ? exp_sig : 16'($urandom);
      do_run(1'b0, -1, len);
      check("rand_sig", signature, exp_sig);
      check("rand_pass", pass, (golden == exp_sig));
    end

    // SO held low: signature never moves
    so_zero = 1'b1;
    golden  = 16'h0000;
    do_run(1'b0, -1, len);
    check("so0_sig", signature, 16'h0000);
    check("so0_pass", pass, 1);
    golden = 16'h0001;
    do_run(1'b0, -1, len);
    check("so0_pass_bad_golden", pass, 0);
    so_zero = 1'b0;

    // Single SO flip during UNLOAD
    init = CL'($urandom);
    load_chain(init);
    exp_sig = ref_sig(init);
    golden  = exp_sig;
    do_run(1'b0, 2 * (CL + 1) + 2, len);
    check("flip_pass", pass, 0);
    check("flip_sig_differs", (signature != exp_sig), 1);

    // Reset during CAPTURE
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (CL) tick;
    check("capture_reached_tm", TM, 0);
    check("capture_reached_busy", busy, 1);
    rst = 1'b1;
    tick;
    check("midrst_tm", TM, 0);
    check("midrst_fifo_write", fifo_write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_signature", signature, 0);
    rst = 1'b0;
    tick;
    check("midrst_stays_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_bist_ctrl.md
# scan_bist_ctrl

Self-contained scan BIST controller for the scan-instrumented FIFO (10-bit data, 4-bit count, single scan chain on TM/SI/SO). On a start pulse it takes over the FIFO's test mode and sequences NUM_PATTERNS load/capture cycles from an internal LFSR. It compresses scan-out into a MISR signature and reports pass/fail against a golden value. It sits beside the FIFO and replaces bench-driven TM/SI toggling in production test.

## Interface
- CHAIN_LEN, 32, scan chain length in flops (≥2)
- NUM_PATTERNS, 16, capture patterns per run (≥1)
- SEED, 16'hACE1, LFSR reload value (nonzero)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request; sampled only in IDLE or DONE
- golden  in  16  expected signature
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  signature == golden; valid while done=1
- signature  out  16  MISR contents
- TM  out  1  FIFO test mode (1 = shift)
- SI  out  1  FIFO scan in
- SO  in  1  FIFO scan out
- fifo_read, fifo_write  out  1 each  FIFO functional strobes during capture
- fifo_d_in  out  10  FIFO functional data during capture

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE/DONE: TM=0, SI=0, fifo strobes=0, fifo_d_in=0. start=1 → SHIFT; LFSR←SEED, MISR←0, shift_cnt←0, pat_cnt←0, done←0, pass←0.
- SHIFT: TM=1, SI=lfsr[15]; LFSR advances every cycle; shift_cnt counts 0..CHAIN_LEN-1, then → CAPTURE.
- CAPTURE (1 cycle): TM=0, fifo_d_in=lfsr[9:0], fifo_write=lfsr[10], fifo_read=lfsr[11]; LFSR holds; pat_cnt++. → UNLOAD if pat_cnt reaches NUM_PATTERNS, else → SHIFT.
- UNLOAD: TM=1, SI=0, CHAIN_LEN cycles; LFSR holds; → DONE.
- In DONE, done=1 and pass=(MISR==golden), latched on entry.
- LFSR: lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- MISR: misr_next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]^SO}. It updates on every SHIFT/UNLOAD cycle except during the first SHIFT pass, which unloads unknown power-on state. signature = misr at all times.
- start while busy: ignored. start in DONE: restarts the run.
- Counters are sized $clog2 of their limit + 1; no wrap inside a run.

## Timing
- Reset: state=IDLE; busy=0, done=0, pass=0, TM=0, SI=0, fifo_read=0, fifo_write=0, fifo_d_in=0, signature=0.
- All outputs are registered or decoded from registered state. busy=1 from the cycle after start is sampled through the last UNLOAD cycle.
- Run length from first SHIFT cycle to DONE entry: NUM_PATTERNS×(CHAIN_LEN+1)+CHAIN_LEN cycles.
- SO is sampled in the same cycle TM=1 drives the shift.
- rst mid-run: the next cycle is IDLE with reset values, and the run is discarded.

## Structure
- Package scan_bist_pkg holds:
  - the state enum
  - LFSR/MISR width (16)
  - tap positions
  - default SEED
  - fifo_d_in width (10)
- One sub-module, scan_lfsr16: 16-bit shifter with shared taps, enable, sync load, and optional serial XOR input. It is instantiated twice, once as the LFSR (serial input tied 0) and once as the MISR (serial input = SO).

## Test plan
- Reset with start=1 held → all outputs at reset values; leaves IDLE only after rst deasserts.
- CHAIN_LEN=4, NUM_PATTERNS=2, start pulse → SI over the first four SHIFT cycles = 1,0,1,0 with TM=1. TM=0 on cycles 5 and 10; done rises after 14 run cycles.
- SO tied 0 → signature stays 16'h0000; golden=0 → pass=1. golden=16'h0001 → pass=0.
- Scoreboard model of the FIFO chain (CHAIN_LEN=4) → signature matches the reference MISR model bit-exact. A single injected SO flip in UNLOAD → pass=0.
- start pulsed mid-SHIFT → no restart, cycle count unchanged. start in DONE → new run with identical signature.
- rst asserted during CAPTURE → next cycle TM=0, fifo_write=0, busy=0, state IDLE.
